// File: rtl/regfile_wb_arb.sv
// Round-robin write-back arbiter feeding the single write port of the 32x32 register file.
// Define RF_WB_BYPASS_EN to add forwarding of the staged write onto the two read ports.
module regfile_wb_arb #(
  parameter int NREQ = 2,
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*5-1:0]    req_rd,
  input  logic [NREQ*XLEN-1:0] req_wdata,
  output logic                 rf_we,
  output logic [4:0]           rf_rd,
  output logic [XLEN-1:0]      rf_wdata,
  output logic [1:0]           grant_id,
  output logic [15:0]          wr_count
`ifdef RF_WB_BYPASS_EN
  ,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  input  logic [XLEN-1:0]      raw_rdata1,
  input  logic [XLEN-1:0]      raw_rdata2,
  output logic [XLEN-1:0]      rdata1,
  output logic [XLEN-1:0]      rdata2
`endif
);

  logic [1:0]      last_grant;
  logic            stage_valid;
  logic            found;
  logic [1:0]      pick;
  logic            xfer;
  logic [4:0]      pick_rd;
  logic [XLEN-1:0] pick_wdata;

  function automatic int rr_slot(input logic [1:0] base, input int k);
    int s;
    s = int'(base) + k;
    return (s >= NREQ) ? s - NREQ : s;
  endfunction

  // Search order starts one past the last winner and wraps.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req_valid[i] && (i == rr_slot(last_grant, k))) begin
          found = 1'b1;
          pick  = 2'(i);
        end
      end
    end
  end

  always_comb begin
    pick_rd    = '0;
    pick_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (int'(pick) == i) begin
        pick_rd    = req_rd[5*i +: 5];
        pick_wdata = req_wdata[XLEN*i +: XLEN];
      end
    end
  end

  assign xfer     = found && !rst;
  assign grant_id = xfer ? pick : 2'd0;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = xfer && (int'(pick) == i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant  <= 2'(NREQ - 1);
      stage_valid <= 1'b0;
      rf_rd       <= '0;
      rf_wdata    <= '0;
      wr_count    <= '0;
    end else begin
      stage_valid <= xfer;
      if (xfer) begin
        rf_rd      <= pick_rd;
        rf_wdata   <= pick_wdata;
        last_grant <= pick;
      end
      if (rf_we) begin
        wr_count <= wr_count + 16'd1;
      end
    end
  end

  // Gating with rst drops a staged write before the file can capture it.
  assign rf_we = stage_valid && (rf_rd != 5'd0) && !rst;

`ifdef RF_WB_BYPASS_EN
  assign rdata1 = (rf_we && (rs1 == rf_rd)) ? rf_wdata : raw_rdata1;
  assign rdata2 = (rf_we && (rs2 == rf_rd)) ? rf_wdata : raw_rdata2;
`endif

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Scoreboard bench for regfile_wb_arb: RR model predicts grants, queue holds expected writes.
module tb_regfile_wb_arb;
  localparam int NREQ = 2;
  localparam int XLEN = 32;
  localparam logic [31:0] OLD_VAL = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [9:0]  req_rd;
  logic [63:0] req_wdata;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [1:0]  grant_id;
  logic [15:0] wr_count;
`ifdef RF_WB_BYPASS_EN
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [31:0] raw_rdata1 = '0;
  logic [31:0] raw_rdata2 = '0;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
`endif

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_exp;
  int m_last = NREQ - 1;
  int m_count = 0;
  logic [31:0] rf_model [32] = '{default: OLD_VAL};
  logic x0_written = 1'b0;

  always #5 clk = ~clk;

  regfile_wb_arb #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_wdata(req_wdata),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .grant_id(grant_id), .wr_count(wr_count)
`ifdef RF_WB_BYPASS_EN
    , .rs1(rs1), .rs2(rs2), .raw_rdata1(raw_rdata1), .raw_rdata2(raw_rdata2),
    .rdata1(rdata1), .rdata2(rdata2)
`endif
  );

  // Behavioural register file that the write port feeds.
  always @(posedge clk) begin
    if (rf_we === 1'b1) begin
      rf_model[rf_rd] <= rf_wdata;
      if (rf_rd == 5'd0) x0_written <= 1'b1;
    end
  end

  // Sample the write port late in the low phase, after stimulus has settled.
  always @(negedge clk) begin
    #2;
    if (rf_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h, expected no write", rf_rd, rf_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({rf_rd, rf_wdata} !== mon_exp) begin
          errors++;
          $display("FAIL wb_data: got rd=%0d data=%h, expected rd=%0d data=%h",
                   rf_rd, rf_wdata, mon_exp[36:32], mon_exp[31:0]);
        end
      end
    end
  end

  function automatic int model_pick(input logic [1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (m_last + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [1:0] onehot(input int g);
    logic [1:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_accept(input int g);
    logic [4:0]  rd;
    logic [31:0] d;
    rd = req_rd[5*g +: 5];
    d  = req_wdata[32*g +: 32];
    m_last = g;
    if (rd != 5'd0) begin
      exp_q.push_back({rd, d});
      m_count++;
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [4:0] r0, input logic [4:0] r1,
                       input logic [31:0] d0, input logic [31:0] d1);
    @(negedge clk);
    req_valid = v;
    req_rd    = {r1, r0};
    req_wdata = {d1, d0};
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid = '0;
    end
    #1;
  endtask

  task automatic test_reset;
    int g;
    rst = 1'b1;
    req_valid = 2'b11;
    req_rd = {5'd2, 5'd1};
    req_wdata = {32'h0202_0202, 32'h0101_0101};
    for (int i = 0; i < 2; i++) begin
      drive(2'b11, 5'd1, 5'd2, 32'h0101_0101, 32'h0202_0202);
      checks++;
      if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b want 00", req_ready); end
      checks++;
      if (rf_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", rf_we); end
    end
    checks++;
    if (rf_rd !== 5'd0 || rf_wdata !== 32'd0) begin
      errors++; $display("FAIL rst_stage: got rd=%0d data=%h want 0/0", rf_rd, rf_wdata);
    end
    checks++;
    if (wr_count !== 16'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", wr_count); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL first_grant: got %b want 01", req_ready); end
    model_accept(0);
    drive(2'b10, 5'd1, 5'd2, 32'h0101_0101, 32'h0202_0202);
    checks++;
    if (rf_we !== 1'b1) begin errors++; $display("FAIL first_we: got %b want 1", rf_we); end
    g = model_pick(req_valid);
    checks++;
    if (req_ready !== onehot(g)) begin errors++; $display("FAIL second_grant: got %b want %b", req_ready, onehot(g)); end
    if (g >= 0) model_accept(g);
    idle(2);
    checks++;
    if (wr_count !== 16'(m_count)) begin errors++; $display("FAIL rst_drain_count: got %0d want %0d", wr_count, m_count); end
  endtask

  task automatic test_round_robin;
    int g;
    for (int i = 0; i < 6; i++) begin
      drive(2'b11, 5'd5, 5'd6, 32'hAAAA_0000 + i, 32'hBBBB_0000 + i);
      g = model_pick(req_valid);
      checks++;
      if (req_ready !== onehot(g) || grant_id !== 2'(g)) begin
        errors++;
        $display("FAIL rr_grant cycle %0d: got ready=%b id=%0d want ready=%b id=%0d", i, req_ready, grant_id, onehot(g), g);
      end
      if (i > 0) begin
        checks++;
        if (rf_we !== 1'b1) begin errors++; $display("FAIL rr_we cycle %0d: got %b want 1", i, rf_we); end
      end
      if (g >= 0) model_accept(g);
    end
    idle(2);
    checks++;
    if (wr_count !== 16'(m_count)) begin errors++; $display("FAIL rr_count: got %0d want %0d", wr_count, m_count); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rr_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_x0_write;
    int g;
    drive(2'b10, 5'd0, 5'd0, 32'h0, 32'hDEAD);
    g = model_pick(req_valid);
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL x0_ready: got %b want 10", req_ready); end
    if (g >= 0) model_accept(g);
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_we: got %b want 0", rf_we); end
    idle(1);
    checks++;
    if (wr_count !== 16'(m_count)) begin errors++; $display("FAIL x0_count: got %0d want %0d", wr_count, m_count); end
    checks++;
    if (x0_written !== 1'b0) begin errors++; $display("FAIL x0_file: got written=%b want 0", x0_written); end
  endtask

  task automatic test_same_rd;
    int g1, g2;
    logic [31:0] later;
    drive(2'b11, 5'd7, 5'd7, 32'h1111, 32'h2222);
    g1 = model_pick(req_valid);
    checks++;
    if (req_ready !== onehot(g1)) begin errors++; $display("FAIL same_rd_first: got %b want %b", req_ready, onehot(g1)); end
    if (g1 >= 0) model_accept(g1);
    drive((g1 == 0) ? 2'b10 : 2'b01, 5'd7, 5'd7, 32'h1111, 32'h2222);
    g2 = model_pick(req_valid);
    checks++;
    if (req_ready !== onehot(g2)) begin errors++; $display("FAIL same_rd_second: got %b want %b", req_ready, onehot(g2)); end
    if (g2 >= 0) model_accept(g2);
    later = (g2 == 0) ? 32'h1111 : 32'h2222;
    idle(2);
    checks++;
    if (rf_model[7] !== later) begin errors++; $display("FAIL same_rd_x7: got %h want %h", rf_model[7], later); end
    checks++;
    if (wr_count !== 16'(m_count)) begin errors++; $display("FAIL same_rd_count: got %0d want %0d", wr_count, m_count); end
  endtask

`ifdef RF_WB_BYPASS_EN
  task automatic test_bypass;
    drive(2'b01, 5'd3, 5'd0, 32'hCAFE_F00D, 32'h0);
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL byp_ready: got %b want 01", req_ready); end
    model_accept(0);
    @(negedge clk);
    req_valid = '0;
    rs1 = 5'd3; raw_rdata1 = 32'h0;
    rs2 = 5'd4; raw_rdata2 = 32'h1234_5678;
    #1;
    checks++;
    if (rdata1 !== 32'hCAFE_F00D) begin errors++; $display("FAIL byp_rdata1: got %h want cafef00d", rdata1); end
    checks++;
    if (rdata2 !== 32'h1234_5678) begin errors++; $display("FAIL byp_rdata2: got %h want 12345678", rdata2); end
    idle(1);
  endtask
`endif

  task automatic test_reset_mid;
    drive(2'b01, 5'd9, 5'd0, 32'h9999_9999, 32'h0);
    checks++;
    if (req_ready !== onehot(model_pick(req_valid))) begin
      errors++; $display("FAIL mid_grant: got %b want %b", req_ready, onehot(model_pick(req_valid)));
    end
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    m_last = NREQ - 1;
    m_count = 0;
    req_valid = 2'b11;
    req_rd = {5'd13, 5'd12};
    req_wdata = {32'hD0D0_0013, 32'hD0D0_0012};
    #1;
    checks++;
    if (rf_we !== 1'b0 || req_ready !== 2'b00) begin
      errors++; $display("FAIL mid_rst: got we=%b ready=%b want 0/00", rf_we, req_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rf_we !== 1'b0 || wr_count !== 16'd0) begin
      errors++; $display("FAIL mid_rst_hold: got we=%b count=%0d want 0/0", rf_we, wr_count);
    end
    checks++;
    if (rf_model[9] !== OLD_VAL) begin errors++; $display("FAIL mid_x9: got %h want %h", rf_model[9], OLD_VAL); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_rearb: got %b want 01", req_ready); end
    model_accept(0);
    idle(2);
    checks++;
    if (rf_model[12] !== 32'hD0D0_0012 || rf_model[9] !== OLD_VAL) begin
      errors++; $display("FAIL mid_after: got x12=%h x9=%h want d0d00012/%h", rf_model[12], rf_model[9], OLD_VAL);
    end
    checks++;
    if (wr_count !== 16'(m_count)) begin errors++; $display("FAIL mid_count: got %0d want %0d", wr_count, m_count); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_x0_write();
    test_same_rd();
`ifdef RF_WB_BYPASS_EN
    test_bypass();
`endif
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL final_drain: got %0d pending want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_wb_arb.md
# regfile_wb_arb

Write-back arbiter for the 32x32 integer register file. Shares the file's single synchronous write port between NREQ write-back sources (ALU, LSU, CSR/mul-div) using round-robin arbitration. The winner is registered into a one-entry output stage that drives the register file write port. Sits between the execute/memory write-back sources and the register file instance; an optional bypass path forwards the staged write to the combinational read ports.

## Interface
- NREQ, default 2: number of write-back requesters, legal 2..4.
- XLEN, default 32: data width.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester write request
- req_ready  out  NREQ  per-requester grant; a transfer occurs on valid&&ready at a rising edge
- req_rd  in  NREQ*5  destination index; slice i = [5i+4:5i]
- req_wdata  in  NREQ*XLEN  write data; slice i = [XLEN*i+XLEN-1:XLEN*i]
- rf_we  out  1  register file write enable (registered)
- rf_rd  out  5  register file write index (registered)
- rf_wdata  out  XLEN  register file write data (registered)
- grant_id  out  2  index of the requester granted this cycle; valid only when any req_ready is high
- wr_count  out  16  count of committed non-x0 writes, wraps at 16'hFFFF to 0
- RF_WB_BYPASS_EN only: rs1, rs2  in  5; raw_rdata1, raw_rdata2  in  XLEN from the register file; rdata1, rdata2  out  XLEN forwarded read data

## Operation
- Arbitration is combinational each cycle over req_valid.
  - Search starts at (last_grant+1) mod NREQ and wraps; the first valid index wins.
  - At most one req_ready is high. req_ready[i] is low whenever req_valid[i] is low.
- No backpressure from the register file: the output stage drains every cycle, so the arbiter grants whenever any request is valid. Throughput is 1 write/cycle.
- On a transfer:
  - stage_valid <= 1; stage_rd <= req_rd[g]; stage_wdata <= req_wdata[g]; last_grant <= g.
  - If no transfer occurs, stage_valid <= 0.
- rf_we = stage_valid && (stage_rd != 0).
  - A write to x0 is accepted (ready high, pointer advances) but never asserts rf_we and is not counted.
- rf_rd and rf_wdata hold the staged values. Their contents when rf_we=0 are don't-care but must not be X after reset; they reset to 0.
- wr_count increments by 1 in each cycle in which rf_we=1.
- Two requesters targeting the same rd in the same cycle are serialized in RR order; the later grant's data is what remains in the file.
- Requesters must hold req_valid, req_rd and req_wdata stable until ready. The arbiter does not check this.

## Timing
- Request sampled at edge E (valid&&ready).
- rf_we/rf_rd/rf_wdata are valid in the cycle after E. The register file captures at edge E+1.
- Request-to-architectural-visibility latency is 2 edges. With bypass, data is visible on rdata1/rdata2 one cycle after E.
- Reset values: rf_we=0, rf_rd=0, rf_wdata=0, wr_count=0, stage_valid=0, last_grant=NREQ-1 (so requester 0 has first priority).
- req_ready and grant_id are combinational and are also gated off while rst=1.
- Reset mid-operation: a staged write is discarded and rf_we=0 in the cycle after the reset edge. No grant is issued while rst is high. Held requests are re-arbitrated from requester 0 after reset deasserts.

## Configuration
- RF_WB_BYPASS_EN defined:
  - rdata1 = (rf_we && rs1==rf_rd) ? rf_wdata : raw_rdata1; rdata2 likewise.
  - rs=0 never forwards, because rf_we is already low for rd=0.
- RF_WB_BYPASS_EN undefined: the rs1/rs2/raw_rdata*/rdata* ports are absent, and consumers must stall one extra cycle on a RAW hazard against the staged write.

## Test plan
- Reset with req_valid=2'b11 held -> req_ready=0, rf_we=0 while rst=1. First grant after reset goes to requester 0; rf_we=1 the next cycle.
- NREQ=2, both requesters continuously valid (rd=5, wdata=A; rd=6, wdata=B) for 6 cycles -> grants alternate 0,1,0,1,0,1. rf_we=1 every cycle from the 2nd cycle on. wr_count=6 two cycles after the last grant.
- Requester 1 writes rd=0, wdata=32'hDEAD -> req_ready[1]=1, rf_we stays 0, wr_count unchanged. x0 still reads 0 via the register file.
- Both requesters target rd=7 (0: 32'h1111, 1: 32'h2222) -> two consecutive rf_we pulses in RR order. Register x7 ends at the later granted value.
- Reset asserted in the cycle after a grant to rd=9 -> rf_we never pulses for rd=9. x9 keeps its old value.
- With RF_WB_BYPASS_EN: staged write rd=3, 32'hCAFE_F00D, with rs1=3 and raw_rdata1=0 -> rdata1=32'hCAFE_F00D. rs2=4 -> rdata2=raw_rdata2.
